prim_sched: RTL and testbench
=============================

// Module: prim_sched
// PURPOSE
//  Sequencer for one prim_calc instance. Accepts a range job [lb, ub] and runs
//  prim_calc once per (block size d, repeat factor r) step, in two passes:
//  bound=ub (added) and bound=lb-1 (subtracted). Step results are accumulated
//  signed, and one range sum is returned per job. Sits between the range
//  reader and the top-level answer adder.
// PARAMETERS
//  DATA_WIDTH       `DATA_WIDTH       width of range bounds and base
//  LONG_DATA_WIDTH  `LONG_DATA_WIDTH  width of prim_calc result and accumulator
//  MAX_DIGITS       10                largest block size d issued
//  R_MAX            3                 r is issued as 1..R_MAX (fits 2-bit r)
//  R_SUB_MASK       4'b0000           bit r set => step with that r is subtracted
//  TIMEOUT          64                max cycles in RUN before abort
// PORTS
//  clock              in   1     single clock, all logic rising-edge
//  reset_n            in   1     asynchronous, active-low reset
//  job_valid          in   1     job offered
//  job_ready          out  1     job accepted when valid&&ready
//  job_lb             in   DW    range lower bound, inclusive
//  job_ub             in   DW    range upper bound, inclusive
//  job_base           in   DW    multiplier forwarded to pc_cur_base
//  pc_input_valid     out  1     prim_calc input_valid (low = clear its state)
//  pc_cur_base_valid  out  1     prim_calc cur_base_valid
//  pc_cur_base        out  DW    prim_calc cur_base_in
//  pc_block_size      out  DW    prim_calc block_size_in (= d)
//  pc_ub              out  DW    prim_calc ub_in (= current pass bound)
//  pc_r               out  2     prim_calc r
//  pc_out_valid       in   1     prim_calc prim_sub_out_valid
//  pc_out             in   LDW   prim_calc prim_sub_out
//  res_valid          out  1     result held until res_ready
//  res_ready          in   1     result consumer ready
//  res_sum            out  LDW   signed sum over all steps, modulo 2^LDW
//  res_err            out  1     job aborted on timeout
//  busy               out  1     high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE. Reset is effective mid-job and drops
//   that job without producing a result.
//  States: IDLE, DIGITS, CLEAR, RUN, ACC, NEXT, DONE.
//  IDLE: job_ready=1. On handshake: latch lb/ub/base, acc=0, pass=0,
//   bound=ub, go to DIGITS.
//  DIGITS: count nd=digits(bound), 1 cycle per compare against 10^k,
//   bound=0 -> nd=1, capped at MAX_DIGITS. Then d=2, r=1. If d>nd, go to NEXT
//   with pass end; otherwise go to CLEAR.
//  CLEAR: exactly 1 cycle with pc_input_valid=0 and pc_cur_base_valid=0.
//   Operands are already stable. Then go to RUN.
//  RUN: pc_input_valid=1, pc_cur_base_valid=1, and operands held constant.
//   Wait for pc_out_valid, then capture pc_out and go to ACC.
//   If TIMEOUT cycles pass in RUN without pc_out_valid: res_err=1, go to DONE.
//  ACC: one cycle. acc += pc_out, or acc -= pc_out when pass=1 XOR
//   R_SUB_MASK[r]. Arithmetic is two's complement with wrap and no saturation.
//  NEXT: r++. If r>R_MAX, then r=1 and d++. If d>nd, the pass ends.
//   End of pass 0: if lb==0 go to DONE, else bound=lb-1, pass=1, go to DIGITS.
//   End of pass 1: go to DONE. Otherwise go to CLEAR.
//  DONE: res_valid=1 with res_sum=acc, held stable until res_ready, then go to
//   IDLE. res_err is cleared when the next job is accepted.
//  lb>ub: still runs both passes. The result is the wrapped difference and no
//   error is raised.
//  pc_* are driven from registers. pc_input_valid=0 outside RUN.
//  A pc_out_valid that arrives in any state other than RUN is ignored.
//  A step whose r makes prim_calc disabled (r>=d, or d odd with r>1) still
//   takes the CLEAR/RUN/ACC path; prim_calc returns 0 for it.
// TESTING (bench uses a prim_calc stub: returns 5, 4 cycles after RUN entry)
//  1 job lb=10 ub=99, mask 0 -> 3 steps (d=2, r=1..3), pass 1 has 0 steps,
//    res_sum=15, res_err=0.
//  2 same job, R_SUB_MASK=4'b1000 -> res_sum=5 (r=3 subtracted).
//  3 job lb=100 ub=999 -> pass 0 has 6 steps, pass 1 (bound 99) has 3 steps;
//    res_sum=30-15=15. Check the 1-cycle pc_input_valid=0 gap before every RUN.
//  4 stub never asserts pc_out_valid -> res_valid with res_err=1 exactly
//    TIMEOUT cycles after RUN entry; the next job runs cleanly with res_err=0.
//  5 res_ready held low 20 cycles -> res_sum and res_valid stable,
//    job_ready=0 until the handshake completes.
//  6 reset_n pulsed low during RUN -> all outputs 0 asynchronously,
//    no res_valid; the next job gives the correct result.

Source files
------------

// File: rtl/prim_sched.sv
// prim_sched: steps one prim_calc through every (d, r) pair for two bound
// passes of a range job and returns the signed running sum.
module prim_sched #(
    parameter int         DATA_WIDTH      = 32,
    parameter int         LONG_DATA_WIDTH = 64,
    parameter int         MAX_DIGITS      = 10,
    parameter int         R_MAX           = 3,
    parameter logic [3:0] R_SUB_MASK      = 4'b0000,
    parameter int         TIMEOUT         = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [DATA_WIDTH-1:0]      job_lb,
    input  logic [DATA_WIDTH-1:0]      job_ub,
    input  logic [DATA_WIDTH-1:0]      job_base,
    output logic                       pc_input_valid,
    output logic                       pc_cur_base_valid,
    output logic [DATA_WIDTH-1:0]      pc_cur_base,
    output logic [DATA_WIDTH-1:0]      pc_block_size,
    output logic [DATA_WIDTH-1:0]      pc_ub,
    output logic [1:0]                 pc_r,
    input  logic                       pc_out_valid,
    input  logic [LONG_DATA_WIDTH-1:0] pc_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [LONG_DATA_WIDTH-1:0] res_sum,
    output logic                       res_err,
    output logic                       busy
);
    localparam int DW = DATA_WIDTH;
    localparam int LDW = LONG_DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE, DIGITS, CLEAR, RUN, ACC, NEXT, DONE
    } state_t;

    state_t         state;
    logic [DW-1:0]  lb_q;
    logic [DW-1:0]  nd;
    logic [LDW-1:0] pow;
    logic [LDW-1:0] cap;
    logic [CW-1:0]  cnt;
    logic           pass;
    logic           pend;

    logic [2:0]    r_inc;
    logic          wrap;
    logic [1:0]    r_new;
    logic [DW-1:0] d_new;
    logic          end_pass;
    logic          sub;
    logic          digit_more;

    always_comb begin
        r_inc      = {1'b0, pc_r} + 3'd1;
        wrap       = r_inc > 3'(R_MAX);
        r_new      = wrap ? 2'd1 : r_inc[1:0];
        d_new      = wrap ? pc_block_size + DW'(1) : pc_block_size;
        end_pass   = pend || (d_new > nd);
        sub        = pass ^ R_SUB_MASK[pc_r];
        digit_more = (nd < DW'(MAX_DIGITS)) && (LDW'(pc_ub) >= pow);
    end

    // res_sum doubles as the accumulator; pc_ub holds the current pass bound.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            job_ready         <= 1'b0;
            pc_input_valid    <= 1'b0;
            pc_cur_base_valid <= 1'b0;
            pc_cur_base       <= '0;
            pc_block_size     <= '0;
            pc_ub             <= '0;
            pc_r              <= '0;
            res_valid         <= 1'b0;
            res_sum           <= '0;
            res_err           <= 1'b0;
            busy              <= 1'b0;
            lb_q              <= '0;
            nd                <= '0;
            pow               <= '0;
            cap               <= '0;
            cnt               <= '0;
            pass              <= 1'b0;
            pend              <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        job_ready   <= 1'b0;
                        busy        <= 1'b1;
                        lb_q        <= job_lb;
                        pc_ub       <= job_ub;
                        pc_cur_base <= job_base;
                        res_sum     <= '0;
                        res_err     <= 1'b0;
                        pass        <= 1'b0;
                        nd          <= DW'(1);
                        pow         <= LDW'(10);
                        state       <= DIGITS;
                    end else begin
                        job_ready <= 1'b1;
                    end
                end
                DIGITS: begin
                    if (digit_more) begin
                        nd  <= nd + DW'(1);
                        pow <= pow * LDW'(10);
                    end else begin
                        pc_block_size <= DW'(2);
                        pc_r          <= 2'd1;
                        if (nd < DW'(2)) begin
                            pend  <= 1'b1;
                            state <= NEXT;
                        end else begin
                            state <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    pc_input_valid    <= 1'b1;
                    pc_cur_base_valid <= 1'b1;
                    cnt               <= '0;
                    state             <= RUN;
                end
                RUN: begin
                    if (pc_out_valid) begin
                        cap               <= pc_out;
                        pc_input_valid    <= 1'b0;
                        pc_cur_base_valid <= 1'b0;
                        state             <= ACC;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        pc_input_valid    <= 1'b0;
                        pc_cur_base_valid <= 1'b0;
                        res_err           <= 1'b1;
                        res_valid         <= 1'b1;
                        state             <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ACC: begin
                    res_sum <= sub ? res_sum - cap : res_sum + cap;
                    state   <= NEXT;
                end
                NEXT: begin
                    if (end_pass) begin
                        pend <= 1'b0;
                        if (!pass && lb_q != '0) begin
                            pass  <= 1'b1;
                            pc_ub <= lb_q - DW'(1);
                            nd    <= DW'(1);
                            pow   <= LDW'(10);
                            state <= DIGITS;
                        end else begin
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        pc_r          <= r_new;
                        pc_block_size <= d_new;
                        state         <= CLEAR;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prim_sched.sv
// tb_prim_sched: two schedulers (add-only and r=3-subtract masks) share
// job and result handshakes; each drives its own prim_calc stub.
module tb_prim_sched;
    localparam int DW = 32;
    localparam int LDW = 64;
    localparam int TO = 64;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          job_valid = 1'b0;
    logic [DW-1:0] job_lb = '0;
    logic [DW-1:0] job_ub = '0;
    logic [DW-1:0] job_base = '0;
    logic          res_ready = 1'b0;
    bit            dead = 1'b0;

    logic           a_job_ready, a_piv, a_pcbv, a_res_valid, a_res_err, a_busy;
    logic [DW-1:0]  a_base, a_bs, a_ub;
    logic [1:0]     a_r;
    logic [LDW-1:0] a_res_sum;
    logic           a_ov = 1'b0;
    int             a_cnt = 0;

    logic           b_job_ready, b_piv, b_pcbv, b_res_valid, b_res_err, b_busy;
    logic [DW-1:0]  b_base, b_bs, b_ub;
    logic [1:0]     b_r;
    logic [LDW-1:0] b_res_sum;
    logic           b_ov = 1'b0;
    int             b_cnt = 0;

    prim_sched #(.TIMEOUT(TO), .R_SUB_MASK(4'b0000)) dut (
        .clock(clock), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(a_job_ready),
        .job_lb(job_lb), .job_ub(job_ub), .job_base(job_base),
        .pc_input_valid(a_piv), .pc_cur_base_valid(a_pcbv),
        .pc_cur_base(a_base), .pc_block_size(a_bs), .pc_ub(a_ub),
        .pc_r(a_r), .pc_out_valid(a_ov), .pc_out(64'd5),
        .res_valid(a_res_valid), .res_ready(res_ready),
        .res_sum(a_res_sum), .res_err(a_res_err), .busy(a_busy)
    );

    prim_sched #(.TIMEOUT(TO), .R_SUB_MASK(4'b1000)) dut_m (
        .clock(clock), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(b_job_ready),
        .job_lb(job_lb), .job_ub(job_ub), .job_base(job_base),
        .pc_input_valid(b_piv), .pc_cur_base_valid(b_pcbv),
        .pc_cur_base(b_base), .pc_block_size(b_bs), .pc_ub(b_ub),
        .pc_r(b_r), .pc_out_valid(b_ov), .pc_out(64'd5),
        .res_valid(b_res_valid), .res_ready(res_ready),
        .res_sum(b_res_sum), .res_err(b_res_err), .busy(b_busy)
    );

    // stubs: return 5 four cycles after RUN entry unless dead
    always @(posedge clock) begin
        if (!a_piv) begin a_cnt <= 0; a_ov <= 1'b0; end
        else begin a_cnt <= a_cnt + 1; a_ov <= (a_cnt == 3) && !dead; end
        if (!b_piv) begin b_cnt <= 0; b_ov <= 1'b0; end
        else begin b_cnt <= b_cnt + 1; b_ov <= (b_cnt == 3) && !dead; end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] sa;
        logic [63:0] sb;
        logic        e;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [63:0] model(input longint lb, input longint ub,
                                          input logic [3:0] mask);
        logic [63:0] acc = '0;
        longint b;
        longint p;
        int nd;
        for (int ps = 0; ps < 2; ps++) begin
            if (ps == 1 && lb == 0) break;
            b = (ps == 1) ? lb - 1 : ub;
            nd = 1;
            p = 10;
            while (nd < 10 && b >= p) begin nd++; p = p * 10; end
            for (int d = 2; d <= nd; d++)
                for (int r = 1; r <= 3; r++)
                    if ((ps == 1) != mask[r]) acc = acc - 64'd5;
                    else acc = acc + 64'd5;
        end
        return acc;
    endfunction

    // RUN-entry monitor: operands must already be stable in the CLEAR cycle
    logic [97:0] prev_ops;
    logic        prev_piv = 1'b0;
    int          runs = 0;
    int          gap_bad = 0;
    always @(negedge clock) begin
        if (a_piv && !prev_piv) begin
            runs++;
            if (prev_ops !== {a_base, a_bs, a_ub, a_r}) gap_bad++;
        end
        if (a_pcbv !== a_piv) gap_bad++;
        prev_piv <= a_piv;
        prev_ops <= {a_base, a_bs, a_ub, a_r};
    end

    task automatic send_job(input logic [31:0] lb, input logic [31:0] ub,
                            input logic [31:0] base, input bit err);
        int n = 0;
        exp_t e;
        @(negedge clock);
        while (!a_job_ready && n < 200) begin @(negedge clock); n++; end
        if (!a_job_ready) begin
            check("job_ready_wait", 0, 1);
            return;
        end
        job_valid = 1'b1;
        job_lb = lb;
        job_ub = ub;
        job_base = base;
        e.sa = err ? 64'd0 : model(lb, ub, 4'b0000);
        e.sb = err ? 64'd0 : model(lb, ub, 4'b1000);
        e.e = err;
        sb_q.push_back(e);
        @(posedge clock);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        @(negedge clock);
        while (!a_piv && n < 200) begin @(negedge clock); n++; end
        if (!a_piv) check("run_wait", 0, 1);
    endtask

    task automatic get_result(input int hold);
        int n = 0;
        int bad = 0;
        logic [63:0] s0;
        exp_t e;
        @(negedge clock);
        while (!a_res_valid && n < 5000) begin @(negedge clock); n++; end
        if (!a_res_valid) begin
            check("res_valid_wait", 0, 1);
            return;
        end
        s0 = a_res_sum;
        repeat (hold) begin
            @(negedge clock);
            if (!a_res_valid || a_res_sum !== s0 || a_job_ready) bad++;
        end
        if (hold > 0) check("hold_stable", bad, 0);
        res_ready = 1'b1;
        if (sb_q.size() == 0) check("sb_empty", 1, 0);
        else begin
            e = sb_q.pop_front();
            check("sum_mask0", a_res_sum, e.sa);
            check("sum_mask8", b_res_sum, e.sb);
            check("res_err", a_res_err, e.e);
        end
        @(posedge clock);
        #1 res_ready = 1'b0;
        @(negedge clock);
        check("res_valid_drop", a_res_valid, 0);
        check("busy_drop", a_busy, 0);
    endtask

    initial begin
        int m;
        int r0;
        repeat (3) @(negedge clock);
        check("reset_outputs", |{a_job_ready, a_piv, a_pcbv, a_base, a_bs,
              a_ub, a_r, a_res_valid, a_res_sum, a_res_err, a_busy}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_ready", a_job_ready, 1);
        check("idle_busy", a_busy, 0);

        send_job(10, 99, 7, 0);
        get_result(0);

        r0 = runs;
        send_job(100, 999, 3, 0);
        wait_run();
        check("run_busy", a_busy, 1);
        check("run_ops", {a_base, a_bs, a_ub, 30'd0, a_r},
              {32'd3, 32'd2, 32'd999, 32'd1});
        get_result(0);
        check("run_count", runs - r0, 9);

        send_job(1000, 50, 1, 0);
        get_result(0);
        send_job(0, 5, 1, 0);
        get_result(0);
        send_job(0, 12345, 2, 0);
        get_result(0);

        send_job(100, 999, 4, 0);
        get_result(20);

        dead = 1'b1;
        send_job(10, 99, 1, 1);
        wait_run();
        m = 0;
        while (!a_res_valid && m < 200) begin @(negedge clock); m++; end
        check("timeout_cycles", m, TO);
        get_result(0);
        dead = 1'b0;
        send_job(10, 99, 1, 0);
        get_result(0);

        send_job(100, 999, 3, 0);
        wait_run();
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check("async_reset", |{a_job_ready, a_piv, a_pcbv, a_base, a_bs,
                 a_ub, a_r, a_res_valid, a_res_sum, a_res_err, a_busy}, 0);
        void'(sb_q.pop_back());
        @(negedge clock);
        reset_n = 1'b1;
        send_job(100, 999, 5, 0);
        get_result(0);

        check("gap_monitor", gap_bad, 0);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
